// File: rtl/counter_sequencer_pkg.sv
// Shared state codes and default tick periods for the counter sequencer.
// Default periods assume the 50 MHz board clock.
package counter_sequencer_pkg;

  localparam int DEF_PERIOD_W = 26;
  localparam int unsigned DEF_PERIOD_0 = 50_000_000;
  localparam int unsigned DEF_PERIOD_1 = 5_000_000;
  localparam int unsigned DEF_PERIOD_2 = 500_000;
  localparam int unsigned DEF_PERIOD_3 = 50_000;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } seq_state_t;

endpackage

// File: rtl/counter_sequencer_tick_prescaler.sv
// Free-running prescaler: counts 0..period-1 while run is high and emits a registered
// one-cycle tick on the terminal count. A period of 0 or 1 ticks on every run cycle.
module tick_prescaler #(
  parameter int W = 26
) (
  input  logic         clk_in,
  input  logic         rst_n,
  input  logic [W-1:0] period,
  input  logic         run,
  input  logic         clear,
  output logic         tick
);

  logic [W-1:0] count;
  logic         terminal;

  // >= rather than == so a count left above a shorter period still terminates
  assign terminal = (period <= W'(1)) || (count >= period - W'(1));

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
      tick  <= 1'b0;
    end else if (clear) begin
      count <= '0;
      tick  <= 1'b0;
    end else if (run) begin
      tick  <= terminal;
      count <= terminal ? '0 : count + W'(1);
    end else begin
      tick  <= 1'b0;
    end
  end

endmodule

// File: rtl/counter_sequencer.sv
// Run/pause/step/limit controller for an external 8-bit counter: issues count enables at a
// selectable rate, a synchronous clear, and stops at a programmed limit.
module counter_sequencer
  import counter_sequencer_pkg::*;
#(
  parameter int          PERIOD_W = DEF_PERIOD_W,
  parameter int unsigned PERIOD_0 = DEF_PERIOD_0,
  parameter int unsigned PERIOD_1 = DEF_PERIOD_1,
  parameter int unsigned PERIOD_2 = DEF_PERIOD_2,
  parameter int unsigned PERIOD_3 = DEF_PERIOD_3
) (
  input  logic       clk_in,
  input  logic       rst_n,
  input  logic       cmd_start,
  input  logic       cmd_stop,
  input  logic       cmd_step,
  input  logic       cmd_clear,
  input  logic [1:0] rate_sel,
  input  logic [7:0] limit,
  input  logic [7:0] cnt_value,
  output logic       cnt_en,
  output logic       cnt_clr,
  output logic [1:0] state,
  output logic       done
);

  seq_state_t          state_q, state_d;
  logic [1:0]          rate_q;
  logic [PERIOD_W-1:0] period;
  logic                tick, run_en, run_tick, limit_hit;
  logic                presc_clr, cnt_en_d, cnt_clr_d;

  always_comb begin
    period = PERIOD_W'(PERIOD_0);
    case (rate_q)
      2'd1:    period = PERIOD_W'(PERIOD_1);
      2'd2:    period = PERIOD_W'(PERIOD_2);
      2'd3:    period = PERIOD_W'(PERIOD_3);
      default: period = PERIOD_W'(PERIOD_0);
    endcase
  end

  assign run_en    = (state_q == ST_RUN);
  assign run_tick  = run_en && tick;
  assign limit_hit = run_tick && (limit != 8'd0) && (cnt_value == limit);

  tick_prescaler #(.W(PERIOD_W)) u_prescaler (
    .clk_in (clk_in),
    .rst_n  (rst_n),
    .period (period),
    .run    (run_en),
    .clear  (presc_clr),
    .tick   (tick)
  );

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Command priority: clear > stop > start > step; a stop also swallows a RUN tick.
  always_comb begin
    state_d = state_q;
    if (cmd_clear) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE, ST_PAUSE, ST_DONE: if (!cmd_stop && cmd_start) state_d = ST_RUN;
        ST_RUN: begin
          if (cmd_stop)       state_d = ST_PAUSE;
          else if (limit_hit) state_d = ST_DONE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    cnt_en_d  = 1'b0;
    cnt_clr_d = 1'b0;
    presc_clr = 1'b0;
    if (cmd_clear) begin
      cnt_clr_d = 1'b1;
      presc_clr = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE, ST_PAUSE: cnt_en_d = !cmd_stop && !cmd_start && cmd_step;
        ST_RUN: begin
          cnt_en_d  = !cmd_stop && run_tick && !limit_hit;
          presc_clr = (rate_sel != rate_q);
        end
        ST_DONE: begin
          cnt_clr_d = !cmd_stop && cmd_start;
          presc_clr = !cmd_stop && cmd_start;
        end
        default: cnt_en_d = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      cnt_en  <= 1'b0;
      cnt_clr <= 1'b0;
      done    <= 1'b0;
      rate_q  <= 2'd0;
    end else begin
      cnt_en  <= cnt_en_d;
      cnt_clr <= cnt_clr_d;
      done    <= (state_d == ST_DONE);
      rate_q  <= rate_sel;
    end
  end

  assign state = state_q;

endmodule
